// File: rtl/mod7_remainder.sv
// mod7_remainder: registered N mod 7 for a 4-bit unsigned input.
// Uses 8 = 1 (mod 7) so one add and one conditional subtract suffice.
module mod7_remainder (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   output logic out_valid,
   output logic X1,
   output logic X2,
   output logic X3
);

   logic [3:0] sum;
   logic [3:0] sum_m7;
   logic [2:0] rem;
   logic [2:0] rem_q;
   logic       vld_q;

   // fold the MSB onto the low three bits, then wrap once at 7
   always_comb begin
      sum    = {3'b000, A} + {1'b0, B, C, D};
      sum_m7 = sum - 4'd7;
      rem    = sum[2:0];
      if (sum >= 4'd7) begin
         rem = sum_m7[2:0];
      end
   end

   // result register: reset wins, hold value when no input accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= 3'b000;
         vld_q <= 1'b0;
      end else begin
         vld_q <= in_valid;
         if (in_valid) begin
            rem_q <= rem;
         end
      end
   end

   assign out_valid = vld_q;
   assign X1        = rem_q[2];
   assign X2        = rem_q[1];
   assign X3        = rem_q[0];

endmodule

// File: tb/tb_mod7_remainder.sv
// tb_mod7_remainder: directed checks of the registered mod-7 block.
// Inputs change on the falling edge; outputs sampled 1 unit after rise.
module tb_mod7_remainder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic A = 1'b0;
   logic B = 1'b0;
   logic C = 1'b0;
   logic D = 1'b0;
   logic out_valid;
   logic X1;
   logic X2;
   logic X3;

   int n_cmp = 0;
   int n_bad = 0;

   mod7_remainder dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .A        (A),
      .B        (B),
      .C        (C),
      .D        (D),
      .out_valid(out_valid),
      .X1       (X1),
      .X2       (X2),
      .X3       (X3)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic v,
                       input logic [3:0] n);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      {A, B, C, D} = n;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 4'b1111);
         n_cmp++;
         if ({X1, X2, X3} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_x[%0d] got %b want 000",
                     i, {X1, X2, X3});
         end
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ov[%0d] got %b want 0",
                     i, out_valid);
         end
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 4'b1111);
         n_cmp++;
         if ({X1, X2, X3} !== 3'b000 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset[%0d] got %b/%b want 000/0",
                     i, {X1, X2, X3}, out_valid);
         end
      end
   endtask

   task automatic test_directed();
      logic [3:0] vin  [5];
      logic [2:0] vexp [5];
      vin  = '{4'b0010, 4'b1011, 4'b1111, 4'b1010, 4'b1100};
      vexp = '{3'b010, 3'b100, 3'b001, 3'b011, 3'b101};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, vin[i]);
         n_cmp++;
         if ({X1, X2, X3} !== vexp[i] || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL directed %b got %b/%b want %b/1",
                     vin[i], {X1, X2, X3}, out_valid, vexp[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [3:0] vin  [6];
      logic [2:0] vexp [6];
      vin  = '{4'b0111, 4'b1110, 4'b0110,
               4'b1101, 4'b1000, 4'b0000};
      vexp = '{3'b000, 3'b000, 3'b110,
               3'b110, 3'b001, 3'b000};
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, vin[i]);
         n_cmp++;
         if ({X1, X2, X3} !== vexp[i] || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap %b got %b/%b want %b/1",
                     vin[i], {X1, X2, X3}, out_valid, vexp[i]);
         end
         n_cmp++;
         if ({X1, X2, X3} === 3'b111) begin
            n_bad++;
            $display("FAIL wrap_no7 %b got 111 want not 111",
                     vin[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] vexp [16];
      vexp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0,
               3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1};
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 4'(i));
         n_cmp++;
         if ({X1, X2, X3} !== vexp[i] || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL sweep N=%0d got %b/%b want %b/1",
                     i, {X1, X2, X3}, out_valid, vexp[i]);
         end
      end
   endtask

   task automatic test_hold();
      logic [3:0] tog [3];
      tog = '{4'b0101, 4'bxxxx, 4'b1110};
      step(1'b0, 1'b1, 4'b1011);
      n_cmp++;
      if ({X1, X2, X3} !== 3'b100 || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL hold_load got %b/%b want 100/1",
                  {X1, X2, X3}, out_valid);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, tog[i]);
         n_cmp++;
         if ({X1, X2, X3} !== 3'b100 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold[%0d] got %b/%b want 100/0",
                     i, {X1, X2, X3}, out_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b0, 1'b1, 4'b1010);
      step(1'b1, 1'b1, 4'b1101);
      n_cmp++;
      if ({X1, X2, X3} !== 3'b000 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid got %b/%b want 000/0",
                  {X1, X2, X3}, out_valid);
      end
      step(1'b0, 1'b1, 4'b1101);
      n_cmp++;
      if ({X1, X2, X3} !== 3'b110 || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_after got %b/%b want 110/1",
                  {X1, X2, X3}, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_wrap();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mod7_remainder.md
Name: mod7_remainder

Overview:
- Computes the remainder of a 4-bit unsigned value divided by 7. The result is a 3-bit code.
- Inputs are four individual bits, A (MSB) through D (LSB). Outputs are three individual bits, X1 (MSB) through X3 (LSB).
- Output is registered: one clock, synchronous active-high reset, one-cycle latency.
- Used as a small arithmetic leaf, for example in check-digit or modular-index logic.

Parameters:
- None. The width is fixed at 4 bits in and 3 bits out.

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- rst  input  1  Synchronous reset, active-high.
- in_valid  input  1  When high, A..D are sampled this cycle.
- A  input  1  Input bit 3 (MSB, weight 8).
- B  input  1  Input bit 2 (weight 4).
- C  input  1  Input bit 1 (weight 2).
- D  input  1  Input bit 0 (LSB, weight 1).
- out_valid  output  1  High for the cycle after an accepted input.
- X1  output  1  Remainder bit 2 (MSB).
- X2  output  1  Remainder bit 1.
- X3  output  1  Remainder bit 0 (LSB).

Behaviour:
- Let N = {A,B,C,D}, an unsigned value from 0 to 15. Define R = N mod 7, range 0..6, and {X1,X2,X3} = R.
- Arithmetic method:
  - Because 8 ≡ 1 (mod 7), form S = A + {B,C,D}. S is 4 bits wide, range 0..8.
  - If S ≥ 7, then R = S − 7; otherwise R = S.
  - A single conditional subtract is sufficient. No division operator is required.
- Full truth table, N → R:
  - 0→0, 1→1, 2→2, 3→3, 4→4, 5→5, 6→6
  - 7→0, 8→1, 9→2, 10→3, 11→4, 12→5, 13→6
  - 14→0, 15→1
- The value 7 (111) never appears on X1..X3.
- Timing:
  - On a rising edge with rst=0 and in_valid=1, the register loads R from the current A..D and sets out_valid=1.
  - The result is visible after that edge (latency 1 cycle).
- On a rising edge with rst=0 and in_valid=0:
  - X1..X3 hold their previous value.
  - out_valid goes to 0.
- Back-to-back inputs: in_valid held high accepts new data every cycle, giving full throughput with no stalls.
- Reset:
  - On a rising edge with rst=1: X1=X2=X3=0 and out_valid=0, regardless of in_valid or A..D.
  - Reset has priority over a simultaneous in_valid.
  - Reset asserted mid-stream discards the input presented on that edge.
  - After rst deasserts, the next accepted input behaves normally.
- Outputs are driven only from flops: no combinational path from inputs to outputs.
- X or Z on A..D while in_valid=0 must not affect the outputs.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, A..D=1111 → X1X2X3=000 and out_valid=0 throughout. Deassert rst → outputs remain 000 until the next accepted input.
- Directed values, in_valid=1, one per cycle: 0010→010, 1011→100, 1111→001, 1010→011, 1100→101. Each result appears one cycle after the input, with out_valid=1.
- Wrap boundaries:
  - 0111→000, 1110→000, 0110→110, 1101→110, 1000→001, 0000→000.
  - Confirm 111 never appears on the outputs.
- Exhaustive sweep: all 16 values back-to-back with in_valid held high. Each output must equal N mod 7 one cycle later, with out_valid high continuously.
- Hold: load 1011 (→100), then drop in_valid and toggle A..D for 3 cycles → outputs stay 100 and out_valid=0.
- Reset mid-stream: in_valid=1, A..D=1101 with rst=1 on the same edge → 000 and out_valid=0. The next cycle with rst=0 and 1101 → 110.
